// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: memory-mapped CPU access to a UART byte stream.
// An RX FIFO buffers bytes from the UART receiver for CPU loads at 0x04.
// A TX FIFO buffers CPU stores to 0x08 for the UART transmitter.
// Load 0x00 returns status {rx_not_empty, tx_not_full}.
// Define UART_FIFO_STATS_EN to add a saturating tx_drop counter.
// The counter is read at 0x0C and cleared by a store to 0x10.
module uart_fifo_bridge #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mmio_addr,
  input  logic        mmio_rd_en,
  input  logic        mmio_wr_en,
  input  logic [7:0]  mmio_wdata,
  output logic [31:0] mmio_rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_RXDATA = 8'h04;
  localparam logic [7:0] ADDR_TXDATA = 8'h08;
  localparam logic [7:0] ADDR_STATS  = 8'h0C;
  localparam logic [7:0] ADDR_CLR    = 8'h10;

  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    tx_mem_q [DEPTH];
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d;
  logic [31:0]   mmio_rdata_q, mmio_rdata_d;
  logic [31:0]   stats_value;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop, store_ok;
  logic [7:0] rx_head;

  // Handshakes and push/pop qualifiers; fullness is always taken pre-update.
  always_comb begin
    rx_empty = (rx_count_q == '0);
    rx_full  = (rx_count_q == FULL_CNT);
    tx_empty = (tx_count_q == '0);
    tx_full  = (tx_count_q == FULL_CNT);
    rx_head  = rx_mem_q[rx_rd_ptr_q];
    tx_data  = tx_mem_q[tx_rd_ptr_q];
    rx_ready = !rst && !rx_full;
    tx_valid = !rst && !tx_empty;
    // A load and store in the same cycle share one address; the load wins.
    store_ok = mmio_wr_en && !mmio_rd_en;
    rx_push  = rx_valid && rx_ready;
    rx_pop   = !rst && mmio_rd_en && (mmio_addr == ADDR_RXDATA) && !rx_empty;
    tx_pop   = tx_valid && tx_ready;
    tx_push  = !rst && store_ok && (mmio_addr == ADDR_TXDATA) && !tx_full;
  end

  // Pointer/count next state; simultaneous push and pop leaves count unchanged.
  always_comb begin
    // NOTE: every always_comb output is assigned a default first so no latch is inferred.
    rx_wr_ptr_d = rx_wr_ptr_q + AW'(rx_push);
    rx_rd_ptr_d = rx_rd_ptr_q + AW'(rx_pop);
    tx_wr_ptr_d = tx_wr_ptr_q + AW'(tx_push);
    tx_rd_ptr_d = tx_rd_ptr_q + AW'(tx_pop);
    rx_count_d  = rx_count_q + CW'(rx_push) - CW'(rx_pop);
    tx_count_d  = tx_count_q + CW'(tx_push) - CW'(tx_pop);
  end

  // Load decode; status and RX head are sampled before any same-cycle update.
  always_comb begin
    mmio_rdata_d = mmio_rdata_q;
    if (mmio_rd_en) begin
      case (mmio_addr)
        ADDR_STATUS: mmio_rdata_d = {30'b0, !rx_empty, !tx_full};
        ADDR_RXDATA: mmio_rdata_d = rx_empty ? 32'h0 : {24'b0, rx_head};
        ADDR_STATS:  mmio_rdata_d = stats_value;
        default:     mmio_rdata_d = 32'h0;
      endcase
    end
  end

`ifdef UART_FIFO_STATS_EN
  logic [31:0] tx_drop_cnt_q, tx_drop_cnt_d;
  logic        tx_drop;

  // Saturating count of stores lost to a full TX FIFO; clear beats increment.
  always_comb begin
    tx_drop       = !rst && store_ok && (mmio_addr == ADDR_TXDATA) && tx_full;
    tx_drop_cnt_d = tx_drop_cnt_q;
    if (store_ok && (mmio_addr == ADDR_CLR))
      tx_drop_cnt_d = '0;
    else if (tx_drop && (tx_drop_cnt_q != '1))
      tx_drop_cnt_d = tx_drop_cnt_q + 32'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) tx_drop_cnt_q <= '0;
    else     tx_drop_cnt_q <= tx_drop_cnt_d;
  end

  assign stats_value = tx_drop_cnt_q;
`else
  assign stats_value = 32'h0;
`endif

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      rx_wr_ptr_q  <= '0;
      rx_rd_ptr_q  <= '0;
      tx_wr_ptr_q  <= '0;
      tx_rd_ptr_q  <= '0;
      rx_count_q   <= '0;
      tx_count_q   <= '0;
      mmio_rdata_q <= '0;
    end else begin
      rx_wr_ptr_q  <= rx_wr_ptr_d;
      rx_rd_ptr_q  <= rx_rd_ptr_d;
      tx_wr_ptr_q  <= tx_wr_ptr_d;
      tx_rd_ptr_q  <= tx_rd_ptr_d;
      rx_count_q   <= rx_count_d;
      tx_count_q   <= tx_count_d;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; cleared pointers and counts make stale bytes unreachable.
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_data;
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= mmio_wdata;
  end

  assign mmio_rdata = mmio_rdata_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: scoreboard bench for uart_fifo_bridge.
// The driver updates a queue-based model of both FIFOs once per cycle.
// It pushes expected load data and accepted TX bytes into scoreboard queues.
// A negedge monitor pops those queues as the DUT presents results.
// Build with UART_FIFO_STATS_EN defined to also exercise the drop counter.
module tb_uart_fifo_bridge;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mmio_addr = '0;
  logic        mmio_rd_en = 1'b0;
  logic        mmio_wr_en = 1'b0;
  logic [7:0]  mmio_wdata = '0;
  logic [31:0] mmio_rdata;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .mmio_addr  (mmio_addr),
    .mmio_rd_en (mmio_rd_en),
    .mmio_wr_en (mmio_wr_en),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  logic [7:0]  m_rx[$];
  logic [7:0]  m_tx[$];
  logic [31:0] m_drops = '0;

  // Scoreboard queues and per-cycle expected handshake levels.
  logic [31:0] rd_exp[$];
  logic [7:0]  tx_exp[$];
  logic        exp_rx_ready = 1'b0;
  logic        exp_tx_valid = 1'b0;
  logic        mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs just after the edge and advance the model.
  task automatic step(input logic rd, input logic wr, input logic [7:0] addr,
                      input logic [7:0] wd, input logic rxv, input logic [7:0] rxd,
                      input logic txr);
    logic [31:0] rv;
    logic rx_ne, tx_full, st_ok;
    @(posedge clk); #1;
    rst = 1'b0;
    mmio_rd_en = rd; mmio_wr_en = wr; mmio_addr = addr; mmio_wdata = wd;
    rx_valid = rxv; rx_data = rxd; tx_ready = txr;

    rx_ne   = (m_rx.size() != 0);
    tx_full = (m_tx.size() == DEPTH);
    st_ok   = wr && !rd;
    exp_rx_ready = (m_rx.size() != DEPTH);
    exp_tx_valid = (m_tx.size() != 0);

    if (rd) begin
      rv = 32'h0;
      if (addr == 8'h00) rv = {30'b0, rx_ne, !tx_full};
      else if (addr == 8'h04 && rx_ne) rv = {24'b0, m_rx[0]};
      else if (addr == 8'h0C) begin
`ifdef UART_FIFO_STATS_EN
        rv = m_drops;
`endif
      end
      rd_exp.push_back(rv);
    end

    if (rd && addr == 8'h04 && rx_ne) void'(m_rx.pop_front());
    if (rxv && exp_rx_ready) m_rx.push_back(rxd);
    if (exp_tx_valid && txr) void'(m_tx.pop_front());
    if (st_ok && addr == 8'h08) begin
      if (!tx_full) begin
        m_tx.push_back(wd);
        tx_exp.push_back(wd);
      end else if (m_drops != 32'hFFFF_FFFF) begin
        m_drops = m_drops + 32'd1;
      end
    end
    if (st_ok && addr == 8'h10) m_drops = 32'h0;
  endtask

  task automatic idle(input logic txr);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, txr);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      mmio_rd_en = 1'b0; mmio_wr_en = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
      m_rx.delete(); m_tx.delete(); tx_exp.delete();
      m_drops = 32'h0;
      exp_rx_ready = 1'b0;
      exp_tx_valid = 1'b0;
    end
  endtask

  // Monitor: compares DUT outputs against scoreboard queues on every falling edge.
  initial begin : monitor
    logic        rd_pending;
    logic        rst_seen;
    logic [31:0] exp_hold;
    logic [31:0] e;
    rd_pending = 1'b0;
    rst_seen   = 1'b0;
    exp_hold   = 32'h0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("rx_ready", {31'b0, rx_ready}, {31'b0, exp_rx_ready});
        check("tx_valid", {31'b0, tx_valid}, {31'b0, exp_tx_valid});
        if (rd_pending) begin
          if (rd_exp.size() == 0) begin
            check("rdata_unexpected", mmio_rdata, 32'hDEAD_BEEF);
          end else begin
            e = rd_exp.pop_front();
            check("rdata", mmio_rdata, e);
            exp_hold = e;
          end
        end else begin
          if (rst_seen) exp_hold = 32'h0;
          check("rdata_hold", mmio_rdata, exp_hold);
        end
        if (tx_valid && tx_ready) begin
          if (tx_exp.size() == 0) begin
            check("tx_unexpected", {24'b0, tx_data}, 32'hFFFF_FFFF);
          end else begin
            e = {24'b0, tx_exp.pop_front()};
            check("tx_data", {24'b0, tx_data}, e);
          end
        end
      end else if (rst_seen) begin
        exp_hold = 32'h0;
      end
      rd_pending = mmio_rd_en && !rst;
      rst_seen   = rst;
    end
  end

  initial begin : driver
    logic [7:0] addr_tbl [6];
    int unsigned p_tx, p_rx;
    logic [7:0] a;
    addr_tbl[0] = 8'h00; addr_tbl[1] = 8'h04; addr_tbl[2] = 8'h08;
    addr_tbl[3] = 8'h0C; addr_tbl[4] = 8'h10; addr_tbl[5] = 8'h14;

    // Reset state: status 0x1, rx_ready high, tx_valid low.
    do_reset(2);
    mon_en = 1'b1;
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    idle(1'b0);

    // RX order and empty read.
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h41, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h42, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h43, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // TX fill with a dropped ninth store, then drain.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h08, 8'h30 + 8'(i), 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH + 3; i++) idle(1'b1);
    check("tx_drained", tx_exp.size(), 0);

    // RX full: same-cycle pop and blocked push.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h50 + 8'(i), 1'b0);
    step(1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 8'hEE, 1'b0);
    idle(1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 8'h00, 1'b0);

    // Drop counter: three drops, read, clear, read.
    for (int i = 0; i < DEPTH + 3; i++) step(1'b0, 1'b1, 8'h08, 8'h60 + 8'(i), 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h0C, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h0C, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h0C, 8'h00, 1'b0, 8'h00, 1'b0);
    // Full TX store while the UART pops is still dropped.
    step(1'b0, 1'b1, 8'h08, 8'h77, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h0C, 8'h00, 1'b0, 8'h00, 1'b0);

    // Reset mid-transfer with 5 TX and 2 RX bytes buffered.
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h08, 8'h70 + 8'(i), 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h81, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h82, 1'b0);
    do_reset(1);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(1'b1);

    // Randomized traffic with varying pressure and occasional resets.
    p_tx = 50; p_rx = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        p_tx = $urandom_range(10, 90);
        p_rx = $urandom_range(10, 90);
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        a = addr_tbl[$urandom_range(0, 5)];
        step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 35), a,
             8'($urandom), ($urandom_range(0, 99) < p_rx), 8'($urandom),
             ($urandom_range(0, 99) < p_tx));
      end
    end

    // Drain and confirm every expectation was consumed.
    for (int i = 0; i < DEPTH + 3; i++) idle(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("final_tx_queue", tx_exp.size(), 0);
    check("final_rd_queue", rd_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
